// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a word-addressed instruction store feeding a
// circular queue. Up to FETCH_WIDTH sequential words are fetched per cycle
// and the decode stage pops 0..FETCH_WIDTH instructions per cycle. Supports
// backpressure, redirect/flush, end-of-memory bounding and a preload port.

// Per-lane address and slot bookkeeping for one fetch/present lane.
module instr_fetch_lane #(
    parameter int LANE      = 0,
    parameter int PW        = 4,
    parameter int CW        = 5,
    parameter int PCW       = 3,
    parameter int AW        = 10,
    parameter int MEM_WORDS = 1024
) (
    input  logic [PW-1:0]  head,
    input  logic [PW-1:0]  tail,
    input  logic [CW-1:0]  cnt,
    input  logic [29:0]    fetch_w,
    input  logic [PCW-1:0] fetch_n,
    output logic [PW-1:0]  rd_slot,
    output logic           slot_valid,
    output logic [PW-1:0]  wr_slot,
    output logic           lane_wr,
    output logic [AW-1:0]  mem_idx,
    output logic           mem_ok
);
    logic [31:0] lane_w;

    // Word this lane would fetch; the full width is kept so the bound
    // compare cannot alias a far-out-of-range PC onto a valid word.
    assign lane_w     = {2'b00, fetch_w} + 32'(LANE);
    assign mem_ok     = lane_w < 32'(MEM_WORDS);
    assign mem_idx    = lane_w[AW-1:0];

    // Presented slot = head+LANE, write slot = tail+LANE; both wrap mod DEPTH.
    assign rd_slot    = head + PW'(LANE);
    assign wr_slot    = tail + PW'(LANE);
    assign slot_valid = 32'(cnt) > 32'(LANE);
    assign lane_wr    = 32'(fetch_n) > 32'(LANE);
endmodule

module instr_fetch_queue #(
    parameter int          FETCH_WIDTH = 4,
    parameter int          DEPTH       = 16,
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ld_en,
    input  logic [31:0]                      ld_addr,
    input  logic [31:0]                      ld_data,
    input  logic                             redirect,
    input  logic [31:0]                      redirect_pc,
    input  logic [$clog2(FETCH_WIDTH+1)-1:0] pop_cnt,
    output logic [32*FETCH_WIDTH-1:0]        out_instr,
    output logic [FETCH_WIDTH-1:0]           out_valid,
    output logic [31:0]                      out_pc,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             fetch_stall
);
    localparam int          PW   = $clog2(DEPTH);
    localparam int          CW   = $clog2(DEPTH+1);
    localparam int          PCW  = $clog2(FETCH_WIDTH+1);
    localparam int          AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEMU = 32'(MEM_WORDS);

    // Storage
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] q   [DEPTH];

    // Queue / PC state
    logic [PW-1:0] head, tail;
    logic [CW-1:0] cnt;
    logic [31:0]   fetch_pc, head_pc;
    logic          stall_q;

    // Fetch / pop decisions
    logic [29:0]    fetch_w;
    logic [31:0]    avail;
    logic [31:0]    free_slots;
    logic [PCW-1:0] fetch_n;
    logic [PCW-1:0] enq_n;
    logic [PCW-1:0] pop_eff;
    logic           want_fetch;
    logic           space_ok;
    logic           fire;

    // Preload decode
    logic [29:0]   ld_w;
    logic          ld_ok;
    logic [AW-1:0] ld_idx;

    // Per-lane wiring
    logic [FETCH_WIDTH-1:0][PW-1:0] rd_slot;
    logic [FETCH_WIDTH-1:0][PW-1:0] wr_slot;
    logic [FETCH_WIDTH-1:0][AW-1:0] mem_idx;
    logic [FETCH_WIDTH-1:0]         mem_ok;
    logic [FETCH_WIDTH-1:0]         lane_wr;
    logic [FETCH_WIDTH-1:0]         slot_valid;
    logic [FETCH_WIDTH-1:0][31:0]   fetch_word;
    logic [FETCH_WIDTH-1:0][31:0]   out_words;

    // Byte-offset bits carry no information; all addresses are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ld_addr[1:0], redirect_pc[1:0], fetch_pc[1:0]};

    // Fetch sizing: bounded by the end of memory and by FETCH_WIDTH.
    assign fetch_w    = fetch_pc[31:2];
    assign avail      = ({2'b00, fetch_w} < MEMU) ? (MEMU - {2'b00, fetch_w}) : 32'h0;
    assign fetch_n    = (avail >= 32'(FETCH_WIDTH)) ? PCW'(FETCH_WIDTH) : PCW'(avail);
    assign want_fetch = (fetch_n != '0);

    // Space test uses the pre-pop count so a fetch never depends on this
    // cycle's pop, keeping the pop path out of the enqueue timing path.
    assign free_slots = 32'(DEPTH) - 32'(cnt);
    assign space_ok   = free_slots >= 32'(FETCH_WIDTH);
    assign fire       = want_fetch && space_ok;
    assign enq_n      = fire ? fetch_n : '0;

    // Over-pop is clamped to what the queue actually holds.
    assign pop_eff    = (32'(pop_cnt) > 32'(cnt)) ? PCW'(cnt) : pop_cnt;

    assign ld_w   = ld_addr[31:2];
    assign ld_ok  = {2'b00, ld_w} < MEMU;
    assign ld_idx = ld_w[AW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
            instr_fetch_lane #(
                .LANE      (gi),
                .PW        (PW),
                .CW        (CW),
                .PCW       (PCW),
                .AW        (AW),
                .MEM_WORDS (MEM_WORDS)
            ) u_lane (
                .head       (head),
                .tail       (tail),
                .cnt        (cnt),
                .fetch_w    (fetch_w),
                .fetch_n    (fetch_n),
                .rd_slot    (rd_slot[gi]),
                .slot_valid (slot_valid[gi]),
                .wr_slot    (wr_slot[gi]),
                .lane_wr    (lane_wr[gi]),
                .mem_idx    (mem_idx[gi]),
                .mem_ok     (mem_ok[gi])
            );

            // Combinational store read; words past the end read as zero.
            assign fetch_word[gi] = mem_ok[gi] ? mem[mem_idx[gi]] : 32'h0;
            assign out_words[gi]  = q[rd_slot[gi]];
        end
    endgenerate

    assign out_instr   = out_words;
    assign out_valid   = slot_valid;
    assign out_pc      = head_pc;
    assign count       = cnt;
    assign fetch_stall = stall_q;

    // Preload port: independent of reset and fetch; a same-cycle fetch of the
    // same word sees the old contents because the read is combinational.
    always_ff @(posedge clk) begin
        if (ld_en && ld_ok)
            mem[ld_idx] <= ld_data;
    end

    // Enqueue fetched words at tail..tail+n-1 (queue data needs no reset).
    always_ff @(posedge clk) begin
        if (!rst && !redirect && fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (lane_wr[i])
                    q[wr_slot[i]] <= fetch_word[i];
            end
        end
    end

    // Pointer, count and PC update; reset beats redirect beats normal flow.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            head_pc  <= {RESET_PC[31:2], 2'b00};
            stall_q  <= 1'b0;
        end else if (redirect) begin
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            head_pc  <= {redirect_pc[31:2], 2'b00};
            stall_q  <= 1'b0;
        end else begin
            if (fire) begin
                tail     <= tail + PW'(fetch_n);
                fetch_pc <= fetch_pc + (32'(fetch_n) << 2);
            end
            head    <= head + PW'(pop_eff);
            head_pc <= head_pc + (32'(pop_eff) << 2);
            cnt     <= cnt + CW'(enq_n) - CW'(pop_eff);
            stall_q <= want_fetch && !space_ok;
        end
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised successor to the 4-wide combinational instruction memory.
- Contains a word-addressed instruction store, a fetch PC and a circular instruction queue.
- Each clock, it fetches up to FETCH_WIDTH sequential words into the queue. The decode stage pops 0..FETCH_WIDTH instructions per cycle.
- Adds backpressure, redirect/flush, end-of-memory bounding and a preload write port.

Parameters:
- FETCH_WIDTH, 4, instructions fetched and presented per cycle (1..8).
- DEPTH, 16, queue entries; power of two, >= 2*FETCH_WIDTH.
- MEM_WORDS, 1024, instruction store size in 32-bit words.
- RESET_PC, 0, byte address loaded into fetch PC and head PC on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_en  in  1  preload write enable.
- ld_addr  in  32  preload byte address; [1:0] ignored.
- ld_data  in  32  preload word.
- redirect  in  1  flush queue and restart fetch.
- redirect_pc  in  32  new fetch byte address; [1:0] ignored.
- pop_cnt  in  $clog2(FETCH_WIDTH+1)  instructions consumed this cycle.
- out_instr  out  32*FETCH_WIDTH  slot i = bits [32i+31:32i] = queue entry head+i.
- out_valid  out  FETCH_WIDTH  bit i = (count > i).
- out_pc  out  32  byte address of slot 0; slot i address is out_pc+4i.
- count  out  $clog2(DEPTH+1)  occupied entries.
- fetch_stall  out  1  high when a fetch was blocked this cycle.

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc and head_pc load RESET_PC.
  - head and tail pointers load 0; count=0; fetch_stall=0.
  - All out_valid read 0; out_instr don't-care.
  - The memory array is not cleared.
  - rst has priority over all other inputs, including mid-fetch and mid-redirect.
- Preload:
  - With ld_en=1, mem[ld_addr[31:2]] <= ld_data.
  - Ignored when ld_addr[31:2] >= MEM_WORDS.
  - Independent of the fetch path.
  - A fetch of the same word in the same cycle returns the old data.
- Fetch (no rst, no redirect):
  - w = fetch_pc[31:2].
  - avail = MEM_WORDS-w if w < MEM_WORDS, else 0.
  - n = min(FETCH_WIDTH, avail).
  - Fetch fires iff n>0 and (DEPTH - count) >= FETCH_WIDTH. count here is the pre-pop value, i.e. the conservative rule.
  - On fire: mem[w..w+n-1] are written to tail..tail+n-1 (mod DEPTH); tail += n; fetch_pc += 4n.
  - Combinational read, so entries are visible on out_* the cycle after the edge.
  - When n>0 but there is insufficient space: fetch_stall=1 (registered) and fetch_pc holds.
  - When n=0 (end of memory): no fetch and fetch_stall=0.
- Pop:
  - eff = min(pop_cnt, count).
  - head += eff (mod DEPTH); head_pc += 4*eff.
  - Over-pop is clamped, never underflows.
- Simultaneous push and pop: count_next = count + n_fired - eff.
- Redirect (redirect=1, no rst):
  - head, tail and count load 0.
  - fetch_pc and head_pc load {redirect_pc[31:2],2'b00}.
  - No enqueue and no pop that cycle; pop_cnt is ignored; fetch_stall=0.
  - First new instructions appear two edges after redirect is asserted: the flush edge, then the fetch edge.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; out_instr slot i indexes (head+i) mod DEPTH.
- Invariants:
  - count <= DEPTH at all times.
  - Entries are always address-contiguous, so out_pc fully describes slot addresses.

Test Plan:
- Reset then steady fetch:
  - Stimulus: preload mem[k]=32'h1000_0000+k for k=0..31; rst 1 cycle; pop_cnt=0.
  - Response: after edge 1, count=4, out_valid=4'b1111, out_instr slot0=32'h1000_0000, out_pc=0.
  - Response: count rises 4,8,12,16 and then holds; fetch_stall=1 from the cycle after count reaches 16.
- Full-rate flow:
  - Stimulus: pop_cnt=4 every cycle after the first fill.
  - Response: count stays at 4; out_pc steps 0x0,0x10,0x20…; slot values match mem; no stall.
- Partial pop and wrap:
  - Stimulus: pop_cnt=3 repeatedly.
  - Response: count grows to 13, where the 16-4 space rule blocks fetch; head wraps past entry 15 correctly.
  - Response: out_instr slot0 matches mem[head_pc>>2] every cycle.
- Redirect mid-stream:
  - Stimulus: with count=12, assert redirect with redirect_pc=0x43 and pop_cnt=4.
  - Response: next cycle count=0 and out_valid=0.
  - Response: following cycle out_pc=0x40, slot0=mem[16], count=4.
- End of memory:
  - Stimulus: redirect_pc=(MEM_WORDS-2)*4.
  - Response: one fetch of n=2; count=2; out_valid=4'b0011; fetch_pc holds at MEM_WORDS*4; no further enqueues; fetch_stall=0.
- Over-pop and reset priority:
  - Stimulus: with count=2, pop_cnt=4.
  - Response: count goes to 0 (clamped); out_pc advances by 8.
  - Stimulus: rst and redirect together.
  - Response: fetch_pc=RESET_PC.
